// File: rtl/calc_pkg.sv
// Shared key codes, operator and state encodings for the calculator.
// Helpers map ASCII keys to operators and operators back to ASCII.
package calc_pkg;

    localparam logic [7:0] KEY_0     = 8'h30;
    localparam logic [7:0] KEY_9     = 8'h39;
    localparam logic [7:0] KEY_ADD   = 8'h2B;
    localparam logic [7:0] KEY_SUB   = 8'h2D;
    localparam logic [7:0] KEY_MUL   = 8'h2A;
    localparam logic [7:0] KEY_DIV   = 8'h2F;
    localparam logic [7:0] KEY_EQ    = 8'h3D;
    localparam logic [7:0] KEY_CLR   = 8'h43;
    localparam logic [7:0] KEY_SPACE = 8'h20;

    typedef enum logic [2:0] {
        NONE,
        ADD,
        SUB,
        MUL,
        DIV
    } op_e;

    typedef enum logic [2:0] {
        ENTRY_A,
        ENTRY_B,
        EXEC,
        SHOW,
        ERROR
    } state_e;

    function automatic op_e key_to_op(input logic [7:0] c);
        op_e o;
        case (c)
            KEY_ADD: o = ADD;
            KEY_SUB: o = SUB;
            KEY_MUL: o = MUL;
            KEY_DIV: o = DIV;
            default: o = NONE;
        endcase
        return o;
    endfunction

    function automatic logic [7:0] op_to_char(input op_e o);
        logic [7:0] c;
        case (o)
            ADD:     c = KEY_ADD;
            SUB:     c = KEY_SUB;
            MUL:     c = KEY_MUL;
            DIV:     c = KEY_DIV;
            default: c = KEY_SPACE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/calc_muldiv.sv
// Iterative unsigned shift-add multiply / restoring divide, VAL_W steps.
// Ports: start (1 cycle) loads and runs step 1; done pulses 1 cycle with result/ovf.
module calc_muldiv
    import calc_pkg::*;
#(
    parameter int VAL_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             start,
    input  logic             is_div,
    input  logic [VAL_W-1:0] opa,
    input  logic [VAL_W-1:0] opb,
    output logic             done,
    output logic [VAL_W-1:0] result,
    output logic             ovf
);

    localparam int CNT_W = $clog2(VAL_W + 1);

    logic               run;
    logic               div_q;
    logic [CNT_W-1:0]   cnt;
    logic [VAL_W-1:0]   m_reg;
    logic [VAL_W-1:0]   s_reg;
    logic [2*VAL_W-1:0] acc;

    logic               src_div;
    logic [VAL_W-1:0]   src_m;
    logic [VAL_W-1:0]   src_s;
    logic [2*VAL_W-1:0] src_acc;
    logic [VAL_W-1:0]   nxt_s;
    logic [2*VAL_W-1:0] nxt_acc;
    logic [VAL_W:0]     rem;
    logic [VAL_W:0]     rem_n;
    logic               ge;

    // On start the first step runs directly on the inputs so the
    // whole operation fits in VAL_W clock edges.
    always_comb begin
        src_div = start ? is_div : div_q;
        src_m   = start ? (is_div ? opb : opa) : m_reg;
        src_s   = start ? (is_div ? opa : opb) : s_reg;
        src_acc = start ? '0 : acc;
        rem     = {src_acc[VAL_W-1:0], src_s[VAL_W-1]};
        ge      = rem >= {1'b0, src_m};
        rem_n   = ge ? rem - {1'b0, src_m} : rem;
        if (src_div) begin
            nxt_s   = {src_s[VAL_W-2:0], ge};
            nxt_acc = {{(VAL_W-1){1'b0}}, rem_n};
        end else begin
            nxt_s   = {src_s[VAL_W-2:0], 1'b0};
            nxt_acc = {src_acc[2*VAL_W-2:0], 1'b0}
                    + {{VAL_W{1'b0}},
                       (src_s[VAL_W-1] ? src_m : '0)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run   <= 1'b0;
            div_q <= 1'b0;
            cnt   <= '0;
            m_reg <= '0;
            s_reg <= '0;
            acc   <= '0;
            done  <= 1'b0;
        end else if (abort) begin
            run   <= 1'b0;
            div_q <= 1'b0;
            cnt   <= '0;
            m_reg <= '0;
            s_reg <= '0;
            acc   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                div_q <= is_div;
                m_reg <= src_m;
                s_reg <= nxt_s;
                acc   <= nxt_acc;
                run   <= 1'b1;
                cnt   <= CNT_W'(VAL_W - 1);
            end else if (run) begin
                s_reg <= nxt_s;
                acc   <= nxt_acc;
                if (cnt == CNT_W'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

    assign result = div_q ? s_reg : acc[VAL_W-1:0];
    assign ovf    = !div_q && (|acc[2*VAL_W-1:VAL_W]);

endmodule

// File: rtl/calc_engine.sv
// Four-function sign+magnitude calculator driven by ASCII key strobes.
// Ports: key_valid/key_char in; disp_value/disp_neg/op_char/busy/result_valid/err out.
module calc_engine
    import calc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int VAL_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [7:0]       key_char,
    output logic [VAL_W-1:0] disp_value,
    output logic             disp_neg,
    output logic [7:0]       op_char,
    output logic             busy,
    output logic             result_valid,
    output logic             err
);

    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam logic [VAL_W-1:0] MAX_V = VAL_W'(10**DIGITS - 1);
    localparam logic [CNT_W-1:0] DIG_C = CNT_W'(DIGITS);

    state_e           state, state_n;
    op_e              op, op_n;
    op_e              pend, pend_n;
    logic [VAL_W-1:0] a_mag, a_mag_n;
    logic             a_neg, a_neg_n;
    logic [CNT_W-1:0] a_cnt, a_cnt_n;
    logic [VAL_W-1:0] b_mag, b_mag_n;
    logic [CNT_W-1:0] b_cnt, b_cnt_n;
    logic             started, started_n;
    logic             rv_n;
    logic             err_n;

    logic             is_dig, is_op, is_eq, is_clr;
    op_e              key_op;
    logic [VAL_W-1:0] dig;

    logic             md_start, md_done, md_ovf;
    logic [VAL_W-1:0] md_res;

    logic             b_eff_neg;
    logic [VAL_W:0]   as_mag;
    logic             as_neg;
    logic             commit, fail;
    logic [VAL_W-1:0] res_mag;
    logic             res_neg;

    assign key_op = key_to_op(key_char);
    assign is_dig = key_char >= KEY_0 && key_char <= KEY_9;
    assign is_op  = key_op != NONE;
    assign is_eq  = key_char == KEY_EQ;
    assign is_clr = key_valid && key_char == KEY_CLR;
    assign dig    = VAL_W'(key_char[3:0]);

    calc_muldiv #(.VAL_W(VAL_W)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .abort  (is_clr),
        .start  (md_start),
        .is_div (op == DIV),
        .opa    (a_mag),
        .opb    (b_mag),
        .done   (md_done),
        .result (md_res),
        .ovf    (md_ovf)
    );

    // Signed add/sub on sign+magnitude; B is always entered non-negative.
    always_comb begin
        b_eff_neg = op == SUB;
        as_neg    = a_neg;
        if (a_neg == b_eff_neg) begin
            as_mag = {1'b0, a_mag} + {1'b0, b_mag};
        end else if (a_mag >= b_mag) begin
            as_mag = {1'b0, a_mag - b_mag};
        end else begin
            as_mag = {1'b0, b_mag - a_mag};
            as_neg = b_eff_neg;
        end
    end

    always_comb begin
        state_n   = state;
        op_n      = op;
        pend_n    = pend;
        a_mag_n   = a_mag;
        a_neg_n   = a_neg;
        a_cnt_n   = a_cnt;
        b_mag_n   = b_mag;
        b_cnt_n   = b_cnt;
        started_n = started;
        err_n     = err;
        rv_n      = 1'b0;
        md_start  = 1'b0;
        commit    = 1'b0;
        fail      = 1'b0;
        res_mag   = '0;
        res_neg   = 1'b0;

        if (is_clr) begin
            state_n   = ENTRY_A;
            op_n      = NONE;
            pend_n    = NONE;
            a_mag_n   = '0;
            a_neg_n   = 1'b0;
            a_cnt_n   = '0;
            b_mag_n   = '0;
            b_cnt_n   = '0;
            started_n = 1'b0;
            err_n     = 1'b0;
        end else begin
            unique case (state)
                ENTRY_A: if (key_valid) begin
                    unique case (1'b1)
                        is_dig: if (a_cnt < DIG_C) begin
                            a_mag_n = a_mag * VAL_W'(10) + dig;
                            a_cnt_n = a_cnt + CNT_W'(1);
                        end
                        is_op: begin
                            op_n    = key_op;
                            state_n = ENTRY_B;
                        end
                        default: ;
                    endcase
                end
                ENTRY_B: if (key_valid) begin
                    unique case (1'b1)
                        is_dig: if (b_cnt < DIG_C) begin
                            b_mag_n = b_mag * VAL_W'(10) + dig;
                            b_cnt_n = b_cnt + CNT_W'(1);
                        end
                        is_op: begin
                            if (b_cnt == '0) begin
                                op_n = key_op;
                            end else begin
                                pend_n    = key_op;
                                started_n = 1'b0;
                                state_n   = EXEC;
                            end
                        end
                        is_eq: if (b_cnt != '0) begin
                            pend_n    = NONE;
                            started_n = 1'b0;
                            state_n   = EXEC;
                        end
                        default: ;
                    endcase
                end
                EXEC: begin
                    unique case (op)
                        ADD, SUB: begin
                            res_mag = as_mag[VAL_W-1:0];
                            res_neg = as_neg;
                            if (as_mag > {1'b0, MAX_V})
                                fail = 1'b1;
                            else
                                commit = 1'b1;
                        end
                        MUL, DIV: begin
                            // B is non-negative, so the sign
                            // XOR reduces to the sign of A.
                            res_mag = md_res;
                            res_neg = a_neg;
                            if (!started) begin
                                if (op == DIV && b_mag == '0) begin
                                    fail = 1'b1;
                                end else begin
                                    md_start  = 1'b1;
                                    started_n = 1'b1;
                                end
                            end else if (md_done) begin
                                if (md_ovf || md_res > MAX_V)
                                    fail = 1'b1;
                                else
                                    commit = 1'b1;
                            end
                        end
                        default: state_n = ENTRY_A;
                    endcase
                end
                SHOW: if (key_valid) begin
                    unique case (1'b1)
                        is_dig: begin
                            a_mag_n = dig;
                            a_neg_n = 1'b0;
                            a_cnt_n = CNT_W'(1);
                            state_n = ENTRY_A;
                        end
                        is_op: begin
                            op_n    = key_op;
                            state_n = ENTRY_B;
                        end
                        default: ;
                    endcase
                end
                ERROR: ;
            endcase
        end

        if (commit) begin
            a_mag_n   = res_mag;
            a_neg_n   = res_neg && (res_mag != '0);
            b_mag_n   = '0;
            b_cnt_n   = '0;
            started_n = 1'b0;
            rv_n      = 1'b1;
            pend_n    = NONE;
            op_n      = pend;
            state_n   = (pend != NONE) ? ENTRY_B : SHOW;
        end
        if (fail) begin
            err_n     = 1'b1;
            started_n = 1'b0;
            state_n   = ERROR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ENTRY_A;
            op           <= NONE;
            pend         <= NONE;
            a_mag        <= '0;
            a_neg        <= 1'b0;
            a_cnt        <= '0;
            b_mag        <= '0;
            b_cnt        <= '0;
            started      <= 1'b0;
            err          <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_n;
            op           <= op_n;
            pend         <= pend_n;
            a_mag        <= a_mag_n;
            a_neg        <= a_neg_n;
            a_cnt        <= a_cnt_n;
            b_mag        <= b_mag_n;
            b_cnt        <= b_cnt_n;
            started      <= started_n;
            err          <= err_n;
            result_valid <= rv_n;
        end
    end

    // B is shown once its first digit arrives; otherwise A.
    logic show_b;
    assign show_b     = state == ENTRY_B && b_cnt != '0;
    assign disp_value = show_b ? b_mag : a_mag;
    assign disp_neg   = !show_b && a_neg && (a_mag != '0);
    assign op_char    = op_to_char(op);
    assign busy       = state == EXEC;

endmodule

// File: doc/calc_engine.md
CALC_ENGINE -- requirements
Module: calc_engine

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning maximum decimal digits per operand and result magnitude (MAX = 10^DIGITS-1).
REQ-002 SHALL have parameter VAL_W, default 16, meaning the magnitude datapath width; it SHALL satisfy 2^VAL_W > MAX.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port key_valid, input, 1, a one-cycle key strobe.
REQ-006 SHALL have port key_char, input, 8, ASCII key: '0'-'9', '+', '-', '*', '/', '=', 'C'.
REQ-007 SHALL have port disp_value, output, VAL_W, the magnitude currently displayed.
REQ-008 SHALL have port disp_neg, output, 1, the sign of disp_value.
REQ-009 SHALL have port op_char, output, 8, the pending operator ASCII, or 8'h20 when none is pending.
REQ-010 SHALL have port busy, output, 1, high while an operation executes.
REQ-011 SHALL have port result_valid, output, 1, a one-cycle pulse when a result is committed.
REQ-012 SHALL have port err, output, 1, sticky flag for overflow or divide-by-zero.

Function
REQ-013 SHALL implement states ENTRY_A, ENTRY_B, EXEC, SHOW, ERROR.
REQ-014 Digit in ENTRY_A/ENTRY_B: SHALL set operand = operand*10 + digit if its digit count < DIGITS; otherwise the digit is ignored.
REQ-015 Operator in ENTRY_A: SHALL latch the operator, show it on op_char, go to ENTRY_B, and keep displaying A.
REQ-016 Operator in ENTRY_B before any B digit: SHALL replace the pending operator only.
REQ-017 Operator in ENTRY_B after a B digit (chaining): SHALL enter EXEC; the result becomes A, the new operator is latched, and the state returns to ENTRY_B.
REQ-018 '=' in ENTRY_B after a B digit: SHALL enter EXEC, then SHOW. '=' in any other state is ignored.
REQ-019 Digit in SHOW: SHALL clear A and start a new ENTRY_A with that digit.
REQ-020 Operator in SHOW: SHALL use the result (sign included) as A and go to ENTRY_B.
REQ-021 'C' in any state, including EXEC and ERROR: SHALL return to ENTRY_A with all registers at reset values within 1 cycle, aborting any operation.
REQ-022 While busy=1, SHALL drop all keys except 'C'. In ERROR, SHALL ignore all keys except 'C'.
REQ-023 Operands and result SHALL be held as sign + magnitude.
REQ-024 '+' and '-' SHALL be signed and complete in 1 EXEC cycle.
REQ-025 '*' SHALL use shift-add over VAL_W cycles.
REQ-026 '/' SHALL use restoring division over VAL_W cycles, truncating toward zero; result sign = XOR of the operand signs.
REQ-027 A zero magnitude SHALL always be shown with disp_neg=0.
REQ-028 Result magnitude > MAX (including intermediate product bits beyond VAL_W) SHALL cause err=1 and state ERROR.
REQ-029 Divisor 0 SHALL cause err=1 and state ERROR without running the iterative loop.
REQ-030 Latency, '=' accepted at cycle t: result_valid and updated disp_value SHALL appear at t+2 for '+'/'-', and at t+VAL_W+2 for '*'/'/'.
REQ-031 busy SHALL be high exactly during the EXEC cycles.
REQ-032 result_valid SHALL pulse on every commit, including chained commits, and SHALL NOT pulse on entry to ERROR.

Reset
REQ-033 On rst_n=0: state ENTRY_A; disp_value=0, disp_neg=0, op_char=8'h20, busy=0, result_valid=0, err=0; all operand and iteration registers cleared.
REQ-034 Reset asserted mid-EXEC SHALL abort the operation with no result_valid pulse.

Structure
REQ-035 Package calc_pkg SHALL hold the key ASCII constants, the operator enum (NONE/ADD/SUB/MUL/DIV), and the state enum.
REQ-036 A sub-module calc_muldiv SHALL implement the iterative multiply/divide with start/done handshake: start one cycle, done one cycle.

Verification
REQ-037 "12+34=": disp_value=46, disp_neg=0, result_valid exactly 2 cycles after '='.
REQ-038 "7-9=": disp_value=2, disp_neg=1. Then "*3=": disp_value=6, disp_neg=1 at VAL_W+2 cycles.
REQ-039 "2+3*4=": chained commit shows 5 with a result_valid pulse, final result 20.
REQ-040 "12345", DIGITS=4: disp_value=1234. Then "*9=": 11106 > 9999, so err=1; a following "5" is ignored; "C" clears all outputs to reset values.
REQ-041 "8/0=": err=1 two cycles after '=' with no result_valid. "9/2=": disp_value=4.
REQ-042 "9*9=", with rst_n pulsed low 5 cycles into EXEC: all outputs at reset values, busy=0, no result_valid.
